piece_queue: RTL and testbench

- Downstream consumer of randombag.
- Requests 7-piece bags over the newbag/ready handshake and unpacks each 21-bit bag into a 14-entry circular FIFO of 3-bit piece codes.
- Dispenses one piece per pop to the game controller and exposes a registered preview of upcoming pieces for the next-piece display.
- Keeps up to two bags buffered so the player never stalls on bag generation.

---
 rtl/tetris_pkg.sv | 17 +
 rtl/bag_checker.sv | 16 +
 rtl/piece_queue.sv | 95 +++++++++
 tb/tb_piece_queue.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the piece generator / queue blocks.
package tetris_pkg;
  typedef logic [2:0] piece_t;

  localparam int NUM_PIECES  = 7;
  localparam int BAG_W       = 21;
  localparam int QUEUE_DEPTH = 14;

  typedef enum logic [1:0] {IDLE, REQ, WAITLOW} piece_queue_state_t;

  // Reduce a pointer sum (at most 13 + 6) back into 0..13.
  function automatic logic [3:0] qwrap(input logic [4:0] v);
    logic [4:0] t;
    t = (v >= 5'(QUEUE_DEPTH)) ? v - 5'(QUEUE_DEPTH) : v;
    return t[3:0];
  endfunction
endpackage

// File: rtl/bag_checker.sv
// Combinational sanity check on a 7-slot bag: flags code 7 or any repeated code.
module bag_checker
  import tetris_pkg::*;
(
  input  logic [BAG_W-1:0] bag,
  output logic             err
);
  always_comb begin
    err = 1'b0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      if (bag[3*i +: 3] == 3'd7) err = 1'b1;
      for (int j = i + 1; j < NUM_PIECES; j++)
        if (bag[3*i +: 3] == bag[3*j +: 3]) err = 1'b1;
    end
  end
endmodule

// File: rtl/piece_queue.sv
// Two-bag circular piece FIFO fed by randombag, with head piece and preview outputs.
// Optional bag checking under `PIECE_QUEUE_BAG_CHECK_EN.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int PREVIEW_N = 3,
  parameter int DEPTH     = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   bag_newbag,
  input  logic                   bag_ready,
  input  logic [20:0]            bag_pieces,
  input  logic                   pop,
  output logic                   piece_valid,
  output logic [2:0]             piece,
  output logic [3*PREVIEW_N-1:0] preview,
  output logic [PREVIEW_N-1:0]   preview_valid,
  output logic [3:0]             count,
  output logic                   bag_error
);
  piece_t             mem [DEPTH];
  logic [3:0]         rd_ptr, wr_ptr, cnt;
  piece_queue_state_t state, nstate;
  logic               newbag_d, cap, pv;

  // Capture only once the request is actually visible to randombag.
  assign cap = (state == REQ) && bag_newbag && bag_ready;
  assign pv  = pop && (cnt != 4'd0);

  always_comb begin
    nstate   = state;
    newbag_d = 1'b0;
    case (state)
      IDLE:    if (cnt <= 4'(NUM_PIECES)) nstate = REQ;
      REQ: begin
        newbag_d = !cap;
        if (cap) nstate = WAITLOW;
      end
      WAITLOW: if (!bag_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bag_newbag <= 1'b0;
    end else begin
      state      <= nstate;
      bag_newbag <= newbag_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (cap) begin
        for (int k = 0; k < NUM_PIECES; k++)
          mem[qwrap({1'b0, wr_ptr} + 5'(k))] <= bag_pieces[3*k +: 3];
        wr_ptr <= qwrap({1'b0, wr_ptr} + 5'(NUM_PIECES));
      end
      if (pv) rd_ptr <= qwrap({1'b0, rd_ptr} + 5'd1);
      // A pop against an empty queue never counts, even alongside a capture.
      cnt <= cnt + (cap ? 4'(NUM_PIECES) : 4'd0) - (pv ? 4'd1 : 4'd0);
    end
  end

  assign count       = cnt;
  assign piece_valid = (cnt != 4'd0);
  assign piece       = piece_valid ? mem[rd_ptr] : '0;

  for (genvar i = 0; i < PREVIEW_N; i++) begin : g_prev
    logic [3:0] idx;
    assign idx              = qwrap({1'b0, rd_ptr} + 5'(i + 1));
    assign preview_valid[i] = (cnt > 4'(i + 1));
    assign preview[3*i +: 3] = preview_valid[i] ? mem[idx] : '0;
  end

`ifdef PIECE_QUEUE_BAG_CHECK_EN
  logic bag_bad, err_q;
  bag_checker u_chk (.bag(bag_pieces), .err(bag_bad));
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              err_q <= 1'b0;
    else if (cap && bag_bad) err_q <= 1'b1;
  end
  assign bag_error = err_q;
`else
  assign bag_error = 1'b0;
`endif
endmodule

// File: tb/tb_piece_queue.sv
// Directed table-driven bench for piece_queue plus hand sequences for reset and bag check.
module tb_piece_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bag_newbag, bag_ready = 1'b0, pop = 1'b0;
  logic [20:0] bag_pieces = '0;
  logic        piece_valid, bag_error;
  logic [2:0]  piece, preview_valid;
  logic [8:0]  preview;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef PIECE_QUEUE_BAG_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [20:0] BAG_A   = 21'h1AC688; // slots 0..6 = 0,1,2,3,4,5,6
  localparam logic [20:0] BAG_C   = 21'h00A72E; // slots 0..6 = 6,5,4,3,2,1,0
  localparam logic [20:0] BAG_DUP = 21'h1AC689; // slot 0 = 1 duplicates slot 1

  piece_queue #(.PREVIEW_N(3), .DEPTH(14)) dut (
    .clk(clk), .reset(reset), .bag_newbag(bag_newbag), .bag_ready(bag_ready),
    .bag_pieces(bag_pieces), .pop(pop), .piece_valid(piece_valid), .piece(piece),
    .preview(preview), .preview_valid(preview_valid), .count(count), .bag_error(bag_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [20:0] bag;
    logic        pop;
    logic        e_nb;
    logic [3:0]  e_cnt;
    logic [2:0]  e_piece;
    logic [8:0]  e_prev;
    logic [2:0]  e_pvld;
  } vec_t;

  vec_t tbl [34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " newbag"}, 32'(bag_newbag), 0);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " piece_valid"}, 32'(piece_valid), 0);
    chk({tag, " piece"}, 32'(piece), 0);
    chk({tag, " preview"}, 32'(preview), 0);
    chk({tag, " preview_valid"}, 32'(preview_valid), 0);
    chk({tag, " bag_error"}, 32'(bag_error), 0);
  endtask

  function automatic vec_t v(input logic r, input logic [20:0] b, input logic p, input logic nb,
                             input logic [3:0] c, input logic [2:0] pc, input logic [8:0] pr,
                             input logic [2:0] pvl);
    vec_t t;
    t.rdy = r; t.bag = b; t.pop = p; t.e_nb = nb; t.e_cnt = c;
    t.e_piece = pc; t.e_prev = pr; t.e_pvld = pvl;
    return t;
  endfunction

  initial begin
    //           rdy bag    pop nb cnt piece prev    pvld
    tbl[0]  = v(0, 0,     0, 0, 0,  0, 9'h000, 3'b000);
    tbl[1]  = v(0, 0,     0, 1, 0,  0, 9'h000, 3'b000);
    tbl[2]  = v(0, 0,     0, 1, 0,  0, 9'h000, 3'b000);
    tbl[3]  = v(1, BAG_A, 0, 0, 7,  0, 9'h0D1, 3'b111);
    tbl[4]  = v(1, BAG_A, 0, 0, 7,  0, 9'h0D1, 3'b111);
    tbl[5]  = v(0, 0,     0, 0, 7,  0, 9'h0D1, 3'b111);
    tbl[6]  = v(0, 0,     0, 0, 7,  0, 9'h0D1, 3'b111);
    tbl[7]  = v(0, 0,     0, 1, 7,  0, 9'h0D1, 3'b111);
    tbl[8]  = v(1, BAG_A, 0, 0, 14, 0, 9'h0D1, 3'b111);
    tbl[9]  = v(0, 0,     0, 0, 14, 0, 9'h0D1, 3'b111);
    tbl[10] = v(0, 0,     0, 0, 14, 0, 9'h0D1, 3'b111);
    tbl[11] = v(0, 0,     1, 0, 13, 1, 9'h11A, 3'b111);
    tbl[12] = v(0, 0,     1, 0, 12, 2, 9'h163, 3'b111);
    tbl[13] = v(0, 0,     1, 0, 11, 3, 9'h1AC, 3'b111);
    tbl[14] = v(0, 0,     1, 0, 10, 4, 9'h035, 3'b111);
    tbl[15] = v(0, 0,     1, 0, 9,  5, 9'h046, 3'b111);
    tbl[16] = v(0, 0,     1, 0, 8,  6, 9'h088, 3'b111);
    tbl[17] = v(0, 0,     1, 0, 7,  0, 9'h0D1, 3'b111);
    tbl[18] = v(0, 0,     1, 0, 6,  1, 9'h11A, 3'b111);
    tbl[19] = v(0, 0,     1, 1, 5,  2, 9'h163, 3'b111);
    tbl[20] = v(0, 0,     1, 1, 4,  3, 9'h1AC, 3'b111);
    tbl[21] = v(0, 0,     1, 1, 3,  4, 9'h035, 3'b011);
    tbl[22] = v(1, BAG_C, 1, 0, 9,  5, 9'h176, 3'b111); // capture + pop at count 3
    tbl[23] = v(0, 0,     1, 0, 8,  6, 9'h12E, 3'b111);
    tbl[24] = v(0, 0,     1, 0, 7,  6, 9'h0E5, 3'b111); // rd_ptr wrapped 13 -> 0
    tbl[25] = v(0, 0,     1, 0, 6,  5, 9'h09C, 3'b111);
    tbl[26] = v(0, 0,     1, 1, 5,  4, 9'h053, 3'b111);
    tbl[27] = v(0, 0,     1, 1, 4,  3, 9'h00A, 3'b111);
    tbl[28] = v(0, 0,     1, 1, 3,  2, 9'h001, 3'b011);
    tbl[29] = v(0, 0,     1, 1, 2,  1, 9'h000, 3'b001);
    tbl[30] = v(0, 0,     1, 1, 1,  0, 9'h000, 3'b000);
    tbl[31] = v(0, 0,     1, 1, 0,  0, 9'h000, 3'b000);
    tbl[32] = v(0, 0,     1, 1, 0,  0, 9'h000, 3'b000); // pop on empty ignored
    tbl[33] = v(1, BAG_C, 1, 0, 7,  6, 9'h0E5, 3'b111); // capture + pop at count 0

    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 34; i++) begin
      bag_ready = tbl[i].rdy; bag_pieces = tbl[i].bag; pop = tbl[i].pop;
      step();
      chk($sformatf("row%0d newbag", i), 32'(bag_newbag), 32'(tbl[i].e_nb));
      chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d piece_valid", i), 32'(piece_valid), 32'(tbl[i].e_cnt != 0));
      chk($sformatf("row%0d piece", i), 32'(piece), 32'(tbl[i].e_piece));
      chk($sformatf("row%0d preview", i), 32'(preview), 32'(tbl[i].e_prev));
      chk($sformatf("row%0d preview_valid", i), 32'(preview_valid), 32'(tbl[i].e_pvld));
    end

    // Reset asserted mid-request drops everything without a clock edge.
    bag_ready = 1'b0; pop = 1'b0;
    step(); step(); step();
    chk("req newbag", 32'(bag_newbag), 1);
    #2 reset = 1'b1;
    #1 chk_zero("async reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Bad bag sets the sticky flag; the data still lands as-is.
    step(); step();
    chk("err newbag", 32'(bag_newbag), 1);
    bag_ready = 1'b1; bag_pieces = BAG_DUP;
    step();
    chk("err flag set", 32'(bag_error), 32'(CHK));
    chk("err count", 32'(count), 7);
    chk("err piece", 32'(piece), 1);
    chk("err preview", 32'(preview), 9'h0D1);
    bag_ready = 1'b0;
    step(); step(); step();
    chk("err renewbag", 32'(bag_newbag), 1);
    bag_ready = 1'b1; bag_pieces = BAG_A;
    step();
    chk("err sticky", 32'(bag_error), 32'(CHK));
    chk("err count2", 32'(count), 14);
    bag_ready = 1'b0;
    step();
    chk("err sticky2", 32'(bag_error), 32'(CHK));
    reset = 1'b1;
    #1 chk_zero("err reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
